// File: rtl/parallel2serial_if.sv
`default_nettype none
// ============================================================================
// Module      : parallel2serial_if
// Description : Byte-in / bit-out handshake bundle for parallel2serial.
// Revision    : 1.0 - initial release
// ============================================================================
interface parallel2serial_if;
    logic [7:0] din_parallel;
    logic       din_valid;
    logic       din_ready;
    logic       dout_serial;
    logic       dout_valid;
    logic       busy;

    modport master (
        output din_parallel,
        output din_valid,
        input  din_ready,
        input  dout_serial,
        input  dout_valid,
        input  busy
    );

    modport slave (
        input  din_parallel,
        input  din_valid,
        output din_ready,
        output dout_serial,
        output dout_valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/parallel2serial.sv
`default_nettype none
// ============================================================================
// Module      : parallel2serial
// Description : 8-bit MSB-first serializer with a one-entry pending buffer;
//               every byte is followed by one idle gap cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel2serial (
    input  logic             clk,
    input  logic             rst_n,
    parallel2serial_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_shifter;
    logic [7:0] w_shifter_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_pend_data;
    logic [7:0] w_pend_data_nxt;
    logic       r_pend_full;
    logic       w_pend_full_nxt;
    logic       r_dout_serial;
    logic       w_dout_serial_nxt;
    logic       r_dout_valid;
    logic       w_dout_valid_nxt;
    logic       w_accept;

    // Ready depends only on registered state, never on din_valid.
    assign bus.din_ready   = ~r_pend_full;
    assign w_accept        = bus.din_valid & ~r_pend_full;
    assign bus.dout_serial = r_dout_serial;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.busy        = (r_state == ST_SHIFT) | r_pend_full;

    always_comb begin
        w_state_nxt       = r_state;
        w_shifter_nxt     = r_shifter;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_pend_data_nxt   = r_pend_data;
        w_pend_full_nxt   = r_pend_full;
        w_dout_serial_nxt = r_dout_serial;
        w_dout_valid_nxt  = r_dout_valid;

        case (r_state)
            ST_IDLE: begin
                // A pending byte always wins; no accept is possible then.
                if (r_pend_full) begin
                    w_dout_serial_nxt = r_pend_data[7];
                    w_dout_valid_nxt  = 1'b1;
                    w_shifter_nxt     = {r_pend_data[6:0], 1'b0};
                    w_bit_cnt_nxt     = 3'd1;
                    w_pend_full_nxt   = 1'b0;
                    w_state_nxt       = ST_SHIFT;
                end else if (w_accept) begin
                    w_dout_serial_nxt = bus.din_parallel[7];
                    w_dout_valid_nxt  = 1'b1;
                    w_shifter_nxt     = {bus.din_parallel[6:0], 1'b0};
                    w_bit_cnt_nxt     = 3'd1;
                    w_state_nxt       = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    w_pend_data_nxt = bus.din_parallel;
                    w_pend_full_nxt = 1'b1;
                end
                // Counter 0 here means bit 0 is already on the line: emit the gap.
                if (r_bit_cnt != 3'd0) begin
                    w_dout_serial_nxt = r_shifter[7];
                    w_dout_valid_nxt  = 1'b1;
                    w_shifter_nxt     = {r_shifter[6:0], 1'b0};
                    w_bit_cnt_nxt     = r_bit_cnt + 3'd1;
                end else begin
                    w_dout_serial_nxt = 1'b0;
                    w_dout_valid_nxt  = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shifter     <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_pend_data   <= 8'h00;
            r_pend_full   <= 1'b0;
            r_dout_serial <= 1'b0;
            r_dout_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shifter     <= w_shifter_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_pend_data   <= w_pend_data_nxt;
            r_pend_full   <= w_pend_full_nxt;
            r_dout_serial <= w_dout_serial_nxt;
            r_dout_valid  <= w_dout_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel2serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel2serial
// Description : Directed scoreboard bench; the monitor deserializes the line
//               like the downstream stage and publishes in the gap cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel2serial;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] q[$];

    parallel2serial_if bif ();

    parallel2serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a byte until it is taken; the expected byte is queued once.
    task automatic send(input logic [7:0] b, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        bif.din_valid    = 1'b1;
        bif.din_parallel = b;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bif.din_ready) done = 1'b1;
            else               waits++;
            @(posedge clk);
            #1;
        end
        bif.din_valid    = 1'b0;
        bif.din_parallel = ~b;
        if (done) q.push_back(b);
        else      chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((bif.busy || bif.dout_valid) && k < 100) begin
            tick(1);
            k++;
        end
        chk("idle_timeout", (k < 100) ? 1 : 0, 1);
        tick(2);
    endtask

    // Downstream deserializer model: collect 8 bits, publish in the gap cycle.
    int         m_bits;
    bit         m_gap_due;
    logic [7:0] m_shreg;
    logic [7:0] m_exp;

    initial begin
        m_bits    = 0;
        m_gap_due = 1'b0;
        m_shreg   = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_bits    = 0;
            m_gap_due = 1'b0;
        end else begin
            if (m_gap_due) begin
                m_gap_due = 1'b0;
                chk("gap_cycle", bif.dout_valid, 0);
                if (q.size() == 0) begin
                    chk("byte_expected", 0, 1);
                end else begin
                    m_exp = q.pop_front();
                    chk("byte_out", m_shreg, m_exp);
                end
            end
            if (bif.dout_valid) begin
                if (m_bits == 0 && q.size() == 0) chk("unexpected_valid", 1, 0);
                m_shreg = {m_shreg[6:0], bif.dout_serial};
                m_bits++;
                if (m_bits == 8) begin
                    m_bits    = 0;
                    m_gap_due = 1'b1;
                end
            end else begin
                chk("serial_zero_when_idle", bif.dout_serial, 0);
            end
        end
    end

    initial begin
        logic [7:0] a5_bits;
        int w;
        int nv;
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bif.din_valid    = 1'b0;
        bif.din_parallel = 8'h00;
        a5_bits          = 8'b1010_0101;

        // Reset state
        tick(2);
        chk("rst_ready", bif.din_ready, 1);
        chk("rst_busy", bif.busy, 0);
        chk("rst_valid", bif.dout_valid, 0);
        chk("rst_serial", bif.dout_serial, 0);
        rst_n = 1'b1;
        tick(1);

        // Single byte A5, bit-by-bit, cycles 1..8 then gap
        send(8'hA5, w);
        chk("a5_latency_valid", bif.dout_valid, 1);
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit_valid", bif.dout_valid, 1);
            chk("a5_bit", bif.dout_serial, a5_bits[7-i]);
            tick(1);
        end
        chk("a5_gap_valid", bif.dout_valid, 0);
        chk("a5_busy_low", bif.busy, 0);

        // Back-to-back A5 then 3C offered in cycle 2
        send(8'hA5, w);
        tick(1);
        send(8'h3C, w);
        chk("b2b_ready_low_c3", bif.din_ready, 0);
        chk("b2b_busy_c3", bif.busy, 1);
        bif.din_parallel = 8'h99;
        tick(6);
        chk("b2b_ready_low_c9", bif.din_ready, 0);
        chk("b2b_gap_c9", bif.dout_valid, 0);
        tick(1);
        chk("b2b_ready_back_c10", bif.din_ready, 1);
        chk("b2b_valid_c10", bif.dout_valid, 1);
        chk("b2b_3c_msb", bif.dout_serial, 0);
        tick(8);
        chk("b2b_gap_c18", bif.dout_valid, 0);
        chk("b2b_busy_c18", bif.busy, 0);

        // Held offer of FF while ready is low
        send(8'h11, w);
        send(8'h22, w);
        chk("held_pend_wait", w, 0);
        send(8'hFF, w);
        chk("held_wait_cycles", w, 8);
        wait_idle();
        chk("held_no_loss", q.size(), 0);

        // Reset at bit 4 of F0 with 0F pending
        send(8'hF0, w);
        send(8'h0F, w);
        tick(2);
        chk("mid_bit4_valid", bif.dout_valid, 1);
        rst_n = 1'b0;
        q.delete();
        tick(1);
        chk("mid_rst_valid", bif.dout_valid, 0);
        chk("mid_rst_ready", bif.din_ready, 1);
        chk("mid_rst_busy", bif.busy, 0);
        rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            if (bif.dout_valid) nv++;
            tick(1);
        end
        chk("mid_rst_no_bits", nv, 0);

        // First accept after reset, then accept on the bit-0 edge (5A after C3)
        send(8'hC3, w);
        chk("post_rst_valid", bif.dout_valid, 1);
        chk("post_rst_msb", bif.dout_serial, 1);
        tick(6);
        send(8'h5A, w);
        chk("coll_wait", w, 0);
        chk("coll_ready_low", bif.din_ready, 0);
        chk("coll_bit0_valid", bif.dout_valid, 1);
        chk("coll_bit0", bif.dout_serial, 1);
        tick(1);
        chk("coll_gap", bif.dout_valid, 0);
        tick(1);
        chk("coll_start_valid", bif.dout_valid, 1);
        chk("coll_5a_msb", bif.dout_serial, 0);
        wait_idle();
        chk("coll_no_loss", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parallel2serial.md
PARALLEL2SERIAL -- requirements
Module: parallel2serial

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 din_parallel  input  8  byte to serialize; sampled only on an accept edge.
REQ-005 din_valid  input  1  upstream offers din_parallel this cycle.
REQ-006 din_ready  output  1  block can take a byte this cycle; accept = din_valid && din_ready at a rising edge.
REQ-007 dout_serial  output  1  serial data bit, MSB first; drives the downstream serial-to-parallel stage's din_serial.
REQ-008 dout_valid  output  1  dout_serial holds a valid bit; drives the downstream stage's din_valid.
REQ-009 busy  output  1  high while a byte is shifting or the pending buffer is full.

Function
REQ-010 The block SHALL contain an 8-bit shift register, a 3-bit bit counter, a one-entry pending buffer with a full flag, and a two-state FSM: IDLE and SHIFT.
REQ-011 din_ready SHALL equal NOT pending-full, derived from registered state only, with no combinational path from din_valid.
REQ-012 dout_serial and dout_valid SHALL be registered outputs.
REQ-013 dout_serial SHALL be 0 whenever dout_valid is 0.
REQ-014 IDLE with pending empty, accept edge: load the byte directly; dout_serial<=din_parallel[7], dout_valid<=1, shifter<=remaining 7 bits, counter<=1, go to SHIFT.
REQ-015 IDLE with pending full: at the next edge, load from the pending buffer exactly as REQ-014, clear pending-full, go to SHIFT.
REQ-016 A byte accepted while in SHIFT SHALL be written into the pending buffer and set pending-full.
REQ-017 An accept edge in IDLE while pending is full cannot occur, because din_ready is 0.
REQ-018 SHIFT, counter 1..7: each edge present the next bit (MSB to LSB) with dout_valid=1 and increment the counter.
REQ-019 SHIFT, counter wraps 7->0 after bit 0 is presented: at the next edge dout_valid<=0, dout_serial<=0, go to IDLE.
REQ-020 Each byte SHALL therefore produce exactly 8 consecutive dout_valid=1 cycles followed by at least one dout_valid=0 cycle.
REQ-021 The mandatory gap in REQ-020 is the cycle in which the downstream stage publishes its byte; back-to-back bytes SHALL never present valid bits in that cycle.
REQ-022 Latency SHALL be 1 cycle from accept edge (IDLE, pending empty) to bit 7 visible on dout_serial.
REQ-023 Peak throughput SHALL be one byte per 9 cycles.
REQ-024 Simultaneous last-bit edge and accept: the byte goes to pending. The next edge drops dout_valid and the one after starts the pending byte.
REQ-025 din_parallel changes while din_ready=0 or din_valid=0 SHALL have no effect.
REQ-026 busy SHALL be (state==SHIFT) OR pending-full.

Reset
REQ-027 rst_n=0 at an edge SHALL force: state IDLE, counter 0, shifter 8'h00, pending-full 0, pending data 8'h00, dout_serial 0, dout_valid 0.
REQ-028 After the same reset edge, din_ready SHALL be 1 and busy SHALL be 0.
REQ-029 Reset mid-byte SHALL discard both the partially shifted byte and any pending byte, with no further valid bits.
REQ-030 No accept SHALL occur on an edge where rst_n=0.
REQ-031 After reset release, the first accept SHALL behave per REQ-014.

Verification
REQ-032 Single byte: accept 8'hA5 in IDLE -> dout_valid=1 for cycles 1-8 with dout_serial 1,0,1,0,0,1,0,1; cycle 9 dout_valid=0; busy low from cycle 9.
REQ-033 Back-to-back: accept 8'hA5 then 8'h3C during its cycle 2 -> din_ready=0 from cycle 3 until pending transfers. Serial output is A5 bits, one gap cycle, then 0,0,1,1,1,1,0,0; din_ready=1 again in the cycle after the transfer.
REQ-034 Held offer: din_valid held high with 8'hFF while din_ready=0 -> exactly one capture when ready rises, no duplicate byte, no loss.
REQ-035 End-to-end: drive the downstream serial-to-parallel stage from dout_serial/dout_valid, send 8'h5A then 8'hC3 -> downstream dout_parallel=8'h5A then 8'hC3, each with a one-cycle dout_valid pulse.
REQ-036 Reset mid-op: assert rst_n=0 at bit 4 of 8'hF0 with 8'h0F pending -> next cycle dout_valid=0, din_ready=1, busy=0, and no bits of either byte emitted afterwards.
REQ-037 Last-bit collision: accept on the edge where bit 0 is presented -> exactly one dout_valid=0 gap cycle, then the new byte starts with no bit dropped.
